// File: rtl/vga_text_writer_if.sv
// Byte-stream input and bus-initiator signals of the VGA text writer.
// master is the writer's view; slave is the source/responder view.
interface vga_text_writer_if;
  logic        char_valid_i;
  logic [7:0]  char_i;
  logic [7:0]  color_i;
  logic        char_ready_o;
  logic        req_o;
  logic        write_enable_o;
  logic [3:0]  mem_be_o;
  logic [31:0] addr_o;
  logic [31:0] write_data_o;

  modport master (
    input  char_valid_i, char_i, color_i,
    output char_ready_o, req_o, write_enable_o,
    output mem_be_o, addr_o, write_data_o
  );

  modport slave (
    output char_valid_i, char_i, color_i,
    input  char_ready_o, req_o, write_enable_o,
    input  mem_be_o, addr_o, write_data_o
  );
endinterface

// File: rtl/vga_text_writer.sv
// Text-console bus initiator: turns a byte stream into char_map/col_map
// writes, tracking a cursor and handling LF, CR, BS and FF.
module vga_text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [31:0] CHAR_BASE  = 32'h0000_0000,
  parameter logic [31:0] COLOR_BASE = 32'h0000_1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  vga_text_writer_if.master bus,
  output logic        busy_o,
  output logic [11:0] cursor_o
);

  localparam int NW = COLS * ROWS / 4;
  localparam int WW = $clog2(NW);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [2:0] {
    IDLE, WR_CHAR, WR_COL, CLR_CHAR, CLR_COL
  } state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [WW-1:0] w;
  logic [7:0]    clr_q;
  logic          req;
  logic [3:0]    be;
  logic [31:0]   addr;
  logic [31:0]   wdata;

  logic [11:0]   cursor;
  logic [RW-1:0] row_inc;
  logic [31:0]   word_p;
  logic [3:0]    be_p;
  logic [WW-1:0] w_nxt;
  logic [31:0]   w_off;
  logic          w_last;
  logic          accept;
  logic          prt, lf, cr, bs, ff;

  always_comb begin
    cursor  = 12'(row) * 12'(COLS) + 12'(col);
    row_inc = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
    word_p  = {20'b0, cursor[11:2], 2'b00};
    be_p    = 4'b0001 << cursor[1:0];
    w_nxt   = w + 1'b1;
    w_off   = 32'({w_nxt, 2'b00});
    w_last  = (w == WW'(NW - 1));
    accept  = bus.char_valid_i && (state == IDLE);
    prt     = (bus.char_i >= 8'h20) && (bus.char_i <= 8'h7E);
    lf      = (bus.char_i == 8'h0A);
    cr      = (bus.char_i == 8'h0D);
    bs      = (bus.char_i == 8'h08);
    ff      = (bus.char_i == 8'h0C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      w     <= '0;
      clr_q <= '0;
      req   <= 1'b0;
      be    <= '0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          clr_q <= bus.color_i;
          unique case (1'b1)
            prt: begin
              state <= WR_CHAR;
              req   <= 1'b1;
              be    <= be_p;
              addr  <= CHAR_BASE + word_p;
              wdata <= {4{bus.char_i}};
            end
            lf: begin
              col <= '0;
              row <= row_inc;
            end
            cr: col <= '0;
            bs: if (cursor != '0) begin
              if (col == '0) begin
                col <= CW'(COLS - 1);
                row <= row - 1'b1;
              end else begin
                col <= col - 1'b1;
              end
            end
            ff: begin
              state <= CLR_CHAR;
              w     <= '0;
              req   <= 1'b1;
              be    <= 4'hF;
              addr  <= CHAR_BASE;
              wdata <= 32'h2020_2020;
            end
            default: ;
          endcase
        end
        WR_CHAR: begin
          state <= WR_COL;
          addr  <= COLOR_BASE + word_p;
          wdata <= {4{clr_q}};
        end
        WR_COL: begin
          state <= IDLE;
          req   <= 1'b0;
          be    <= '0;
          addr  <= '0;
          wdata <= '0;
          if (col == CW'(COLS - 1)) begin
            col <= '0;
            row <= row_inc;
          end else begin
            col <= col + 1'b1;
          end
        end
        CLR_CHAR: begin
          if (w_last) begin
            state <= CLR_COL;
            w     <= '0;
            addr  <= COLOR_BASE;
            wdata <= {4{clr_q}};
          end else begin
            w    <= w_nxt;
            addr <= CHAR_BASE + w_off;
          end
        end
        CLR_COL: begin
          if (w_last) begin
            state <= IDLE;
            req   <= 1'b0;
            be    <= '0;
            addr  <= '0;
            wdata <= '0;
            row   <= '0;
            col   <= '0;
          end else begin
            w    <= w_nxt;
            addr <= COLOR_BASE + w_off;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.char_ready_o   = (state == IDLE);
  assign bus.req_o          = req;
  assign bus.write_enable_o = req;
  assign bus.mem_be_o       = be;
  assign bus.addr_o         = addr;
  assign bus.write_data_o   = wdata;
  assign busy_o             = (state != IDLE);
  assign cursor_o           = cursor;

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed self-checking bench for vga_text_writer.
// Drives bytes one at a time and checks every bus cycle.
module tb_vga_text_writer;
  logic        clk;
  logic        rst;
  logic        busy;
  logic [11:0] cursor;
  int          n_tests;
  int          n_fail;

  vga_text_writer_if bus ();

  vga_text_writer dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .busy_o   (busy),
    .cursor_o (cursor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_req"}, 32'(bus.req_o), 0);
    chk({tag, "_we"}, 32'(bus.write_enable_o), 0);
    chk({tag, "_be"}, 32'(bus.mem_be_o), 0);
    chk({tag, "_addr"}, bus.addr_o, 0);
    chk({tag, "_data"}, bus.write_data_o, 0);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] co);
    int i;
    for (i = 0; i < 3000 && !bus.char_ready_o; i++) tick();
    if (!bus.char_ready_o) begin
      chk("ready_timeout", 32'(bus.char_ready_o), 1);
      $display("FAIL ready_timeout");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "writer stuck busy");
    end
    bus.char_i       = c;
    bus.color_i      = co;
    bus.char_valid_i = 1'b1;
    tick();
    bus.char_valid_i = 1'b0;
  endtask

  task automatic put_char(input logic [7:0] c, input logic [7:0] co,
                          input int p, input int next_p);
    logic [31:0] wa;
    logic [3:0]  eb;
    wa = 32'((p / 4) * 4);
    eb = 4'(1 << (p % 4));
    send(c, co);
    chk("wc_req", 32'(bus.req_o), 1);
    chk("wc_we", 32'(bus.write_enable_o), 1);
    chk("wc_addr", bus.addr_o, wa);
    chk("wc_be", 32'(bus.mem_be_o), 32'(eb));
    chk("wc_data", bus.write_data_o, {4{c}});
    chk("wc_rdy", 32'(bus.char_ready_o), 0);
    tick();
    chk("wk_req", 32'(bus.req_o), 1);
    chk("wk_addr", bus.addr_o, 32'h1000 + wa);
    chk("wk_be", 32'(bus.mem_be_o), 32'(eb));
    chk("wk_data", bus.write_data_o, {4{co}});
    chk("wk_busy", 32'(busy), 1);
    tick();
    chk("wd_req", 32'(bus.req_o), 0);
    chk("wd_rdy", 32'(bus.char_ready_o), 1);
    chk("wd_cur", 32'(cursor), 32'(next_p));
  endtask

  task automatic ctrl(input logic [7:0] c, input int next_p);
    send(c, 8'h00);
    chk("ctl_req", 32'(bus.req_o), 0);
    chk("ctl_rdy", 32'(bus.char_ready_o), 1);
    chk("ctl_cur", 32'(cursor), 32'(next_p));
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.char_valid_i = 1'b0;
    bus.char_i       = 8'h00;
    bus.color_i      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.char_ready_o), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cur", 32'(cursor), 0);
    chk_idle_bus("rst");
    rst = 1'b0;
    tick();

    // 'A' at cell 0, then five more; cell 5 lands in word 1, lane 1
    put_char(8'h41, 8'h1F, 0, 1);
    put_char(8'h42, 8'h1F, 1, 2);
    put_char(8'h43, 8'h1F, 2, 3);
    put_char(8'h44, 8'h1F, 3, 4);
    put_char(8'h45, 8'h1F, 4, 5);
    put_char(8'h46, 8'h2E, 5, 6);

    ctrl(8'h0D, 0);
    ctrl(8'h0A, 80);
    ctrl(8'h08, 79);
    ctrl(8'h0D, 0);
    ctrl(8'h08, 0);
    ctrl(8'h01, 0);
    ctrl(8'h7F, 0);

    for (int r = 1; r < 30; r++) ctrl(8'h0A, r * 80);
    for (int k = 0; k < 79; k++)
      put_char(8'(8'h30 + (k % 40)), 8'h05, 2320 + k, 2321 + k);
    // last cell: word 0x95C lane 3, cursor wraps to top
    put_char(8'h5A, 8'h4C, 2399, 0);

    ctrl(8'h0A, 80);
    send(8'h0C, 8'h07);
    for (int k = 0; k < 1200; k++) begin
      chk("clr_req", 32'(bus.req_o), 1);
      chk("clr_be", 32'(bus.mem_be_o), 32'hF);
      if (k < 600) begin
        chk("clr_caddr", bus.addr_o, 32'(k * 4));
        chk("clr_cdata", bus.write_data_o, 32'h2020_2020);
      end else begin
        chk("clr_kaddr", bus.addr_o, 32'h1000 + 32'((k - 600) * 4));
        chk("clr_kdata", bus.write_data_o, 32'h0707_0707);
      end
      tick();
    end
    chk("clr_end_req", 32'(bus.req_o), 0);
    chk("clr_end_rdy", 32'(bus.char_ready_o), 1);
    chk("clr_end_cur", 32'(cursor), 0);

    put_char(8'h42, 8'h07, 0, 1);
    send(8'h0C, 8'h07);
    repeat (300) tick();
    chk("mid_req", 32'(bus.req_o), 1);
    chk("mid_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_rdy", 32'(bus.char_ready_o), 1);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_cur", 32'(cursor), 0);
    chk_idle_bus("mrst");
    tick();
    rst = 1'b0;
    tick();
    chk("post_rdy", 32'(bus.char_ready_o), 1);
    chk_idle_bus("post");
    put_char(8'h43, 8'h11, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
